// File: rtl/bp_lce_mem_responder_pkg.sv
// Shared types for the LCE memory-packet responder.
//   bp_lce_mem_op_e           : 2-bit packet opcode
//   DECLARE_BP_LCE_MEM_PKT_S  : declares bp_lce_mem_pkt_s, laid out MSB-first as
//                               {opcode, index, way, wmask, wdata}. The field widths
//                               come from the set count, associativity and entry width.

`ifndef BP_LCE_MEM_RESPONDER_PKG_MACROS
`define BP_LCE_MEM_RESPONDER_PKG_MACROS
`define DECLARE_BP_LCE_MEM_PKT_S(sets_mp, assoc_mp, entry_width_mp) \
    typedef struct packed { \
        bp_lce_mem_responder_pkg::bp_lce_mem_op_e opcode; \
        logic [$clog2(sets_mp)-1:0]              index; \
        logic [$clog2(assoc_mp)-1:0]             way; \
        logic [(entry_width_mp)-1:0]             wmask; \
        logic [(entry_width_mp)-1:0]             wdata; \
    } bp_lce_mem_pkt_s
`endif

package bp_lce_mem_responder_pkg;

    typedef enum logic [1:0] {
        e_mem_read  = 2'd0,
        e_mem_write = 2'd1,
        e_mem_clear = 2'd2,
        e_mem_rsvd  = 2'd3
    } bp_lce_mem_op_e;

    localparam int unsigned OpcodeWidth = 2;

endpackage

// File: rtl/bp_lce_mem_responder_port.sv
// One array's LCE packet responder: arbitration against the cache pipeline, SRAM drive,
// read-return way mux with hold register, and a starvation counter.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   pipe_v_i              pipeline owns the array this cycle (always wins)
//   mem_pkt_v_i/_i        LCE packet valid and payload
//   mem_pkt_yumi_o        packet consumed this cycle
//   mem_o                 read data for the selected way (held between reads)
//   sram_*_o / sram_data_i  single-port SRAM drive, one-cycle read latency
//   starved_o             packet has been blocked for starve_limit_p cycles

module bp_lce_mem_responder_port
    import bp_lce_mem_responder_pkg::*;
#(
    parameter int unsigned sets_p         = 64,
    parameter int unsigned assoc_p        = 8,
    parameter int unsigned entry_width_p  = 32,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                                                clk_i,
    input  logic                                                reset_i,
    input  logic                                                pipe_v_i,
    input  logic                                                mem_pkt_v_i,
    input  logic [2+$clog2(sets_p)+$clog2(assoc_p)+2*entry_width_p-1:0] mem_pkt_i,
    output logic                                                mem_pkt_yumi_o,
    output logic [entry_width_p-1:0]                            mem_o,
    output logic                                                sram_v_o,
    output logic                                                sram_w_o,
    output logic [$clog2(sets_p)-1:0]                           sram_addr_o,
    output logic [assoc_p*entry_width_p-1:0]                    sram_data_o,
    output logic [assoc_p*entry_width_p-1:0]                    sram_mask_o,
    input  logic [assoc_p*entry_width_p-1:0]                    sram_data_i,
    output logic                                                starved_o
);

    localparam int unsigned WayWidth = $clog2(assoc_p);
    localparam int unsigned CntWidth = $clog2(starve_limit_p + 1);

    `DECLARE_BP_LCE_MEM_PKT_S(sets_p, assoc_p, entry_width_p);

    bp_lce_mem_pkt_s pkt;
    assign pkt = mem_pkt_i;

    logic yumi;
    assign yumi           = mem_pkt_v_i & ~pipe_v_i & ~reset_i;
    assign mem_pkt_yumi_o = yumi;

    // SRAM drive: all fields zero unless a packet is consumed this cycle.
    always_comb begin
        sram_v_o    = 1'b0;
        sram_w_o    = 1'b0;
        sram_addr_o = '0;
        sram_data_o = '0;
        sram_mask_o = '0;
        if (yumi) begin
            unique case (pkt.opcode)
                e_mem_read: begin
                    sram_v_o    = 1'b1;
                    sram_addr_o = pkt.index;
                end
                e_mem_write: begin
                    sram_v_o    = 1'b1;
                    sram_w_o    = 1'b1;
                    sram_addr_o = pkt.index;
                    sram_data_o = {assoc_p{pkt.wdata}};
                    for (int unsigned i = 0; i < assoc_p; i++) begin
                        if (i == 32'(pkt.way)) begin
                            sram_mask_o[i*entry_width_p +: entry_width_p] = pkt.wmask;
                        end
                    end
                end
                e_mem_clear: begin
                    sram_v_o    = 1'b1;
                    sram_w_o    = 1'b1;
                    sram_addr_o = pkt.index;
                    for (int unsigned i = 0; i < assoc_p; i++) begin
                        if (i == 32'(pkt.way)) begin
                            sram_mask_o[i*entry_width_p +: entry_width_p] = '1;
                        end
                    end
                end
                e_mem_rsvd: begin
                    // Consumed without touching the SRAM.
                end
            endcase
        end
    end

    // Read return path.
    logic                     rd_pend_d, rd_pend_q;
    logic [WayWidth-1:0]      way_d, way_q;
    logic [entry_width_p-1:0] hold_d, hold_q;
    logic [entry_width_p-1:0] rd_slice;

    assign rd_pend_d = yumi & (pkt.opcode == e_mem_read);
    assign way_d     = rd_pend_d ? pkt.way : way_q;

    always_comb begin
        rd_slice = '0;
        for (int unsigned i = 0; i < assoc_p; i++) begin
            if (i == 32'(way_q)) begin
                rd_slice = sram_data_i[i*entry_width_p +: entry_width_p];
            end
        end
    end

    // Returning data passes straight through and is captured for later cycles.
    assign hold_d = rd_pend_q ? rd_slice : hold_q;
    assign mem_o  = hold_d;

    // Starvation: the count includes the current blocked cycle, so starved_o rises
    // in the limit-th blocked cycle and drops in the cycle the packet is consumed.
    logic                blocked;
    logic [CntWidth-1:0] cnt_d, cnt_q;

    assign blocked = mem_pkt_v_i & ~yumi & ~reset_i;

    always_comb begin
        cnt_d = '0;
        if (blocked) begin
            cnt_d = (cnt_q == CntWidth'(starve_limit_p)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign starved_o = (cnt_d == CntWidth'(starve_limit_p));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pend_q <= 1'b0;
            way_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            way_q     <= way_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    // The reserved opcode is a protocol error; flagged in simulation only.
    a_no_rsvd_op: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi && pkt.opcode == e_mem_rsvd))
        else $error("reserved LCE memory opcode consumed");

endmodule

// File: rtl/bp_lce_mem_responder.sv
// Cache-side responder for LCE tag/data/stat memory packets. Each array has its own
// independent responder slice that arbitrates against the cache pipeline, drives the
// array's single-port SRAM and returns read data the cycle after the handshake.
// Ports (X in tag, data, stat):
//   clk_i, reset_i            clock, asynchronous active-high reset
//   pipe_X_v_i                pipeline claims array X
//   X_mem_pkt_v_i/_i/_yumi_o  LCE packet handshake {opcode, index, way, wmask, wdata}
//   X_mem_o                   read data of the selected way
//   X_sram_*                  SRAM enable/write/row/data/mask and read row
//   X_starved_o               packet blocked for starve_limit_p cycles

module bp_lce_mem_responder
    import bp_lce_mem_responder_pkg::*;
#(
    parameter int unsigned sets_p             = 64,
    parameter int unsigned assoc_p            = 8,
    parameter int unsigned tag_entry_width_p  = 32,
    parameter int unsigned data_entry_width_p = 512,
    parameter int unsigned stat_entry_width_p = 2,
    parameter int unsigned starve_limit_p     = 8
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic                                      pipe_tag_v_i,
    input  logic                                      tag_mem_pkt_v_i,
    input  logic [2+$clog2(sets_p)+$clog2(assoc_p)+2*tag_entry_width_p-1:0] tag_mem_pkt_i,
    output logic                                      tag_mem_pkt_yumi_o,
    output logic [tag_entry_width_p-1:0]              tag_mem_o,
    output logic                                      tag_sram_v_o,
    output logic                                      tag_sram_w_o,
    output logic [$clog2(sets_p)-1:0]                 tag_sram_addr_o,
    output logic [assoc_p*tag_entry_width_p-1:0]      tag_sram_data_o,
    output logic [assoc_p*tag_entry_width_p-1:0]      tag_sram_mask_o,
    input  logic [assoc_p*tag_entry_width_p-1:0]      tag_sram_data_i,
    output logic                                      tag_starved_o,

    input  logic                                      pipe_data_v_i,
    input  logic                                      data_mem_pkt_v_i,
    input  logic [2+$clog2(sets_p)+$clog2(assoc_p)+2*data_entry_width_p-1:0] data_mem_pkt_i,
    output logic                                      data_mem_pkt_yumi_o,
    output logic [data_entry_width_p-1:0]             data_mem_o,
    output logic                                      data_sram_v_o,
    output logic                                      data_sram_w_o,
    output logic [$clog2(sets_p)-1:0]                 data_sram_addr_o,
    output logic [assoc_p*data_entry_width_p-1:0]     data_sram_data_o,
    output logic [assoc_p*data_entry_width_p-1:0]     data_sram_mask_o,
    input  logic [assoc_p*data_entry_width_p-1:0]     data_sram_data_i,
    output logic                                      data_starved_o,

    input  logic                                      pipe_stat_v_i,
    input  logic                                      stat_mem_pkt_v_i,
    input  logic [2+$clog2(sets_p)+$clog2(assoc_p)+2*stat_entry_width_p-1:0] stat_mem_pkt_i,
    output logic                                      stat_mem_pkt_yumi_o,
    output logic [stat_entry_width_p-1:0]             stat_mem_o,
    output logic                                      stat_sram_v_o,
    output logic                                      stat_sram_w_o,
    output logic [$clog2(sets_p)-1:0]                 stat_sram_addr_o,
    output logic [assoc_p*stat_entry_width_p-1:0]     stat_sram_data_o,
    output logic [assoc_p*stat_entry_width_p-1:0]     stat_sram_mask_o,
    input  logic [assoc_p*stat_entry_width_p-1:0]     stat_sram_data_i,
    output logic                                      stat_starved_o
);

    bp_lce_mem_responder_port #(
        .sets_p         (sets_p),
        .assoc_p        (assoc_p),
        .entry_width_p  (tag_entry_width_p),
        .starve_limit_p (starve_limit_p)
    ) u_tag (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .pipe_v_i       (pipe_tag_v_i),
        .mem_pkt_v_i    (tag_mem_pkt_v_i),
        .mem_pkt_i      (tag_mem_pkt_i),
        .mem_pkt_yumi_o (tag_mem_pkt_yumi_o),
        .mem_o          (tag_mem_o),
        .sram_v_o       (tag_sram_v_o),
        .sram_w_o       (tag_sram_w_o),
        .sram_addr_o    (tag_sram_addr_o),
        .sram_data_o    (tag_sram_data_o),
        .sram_mask_o    (tag_sram_mask_o),
        .sram_data_i    (tag_sram_data_i),
        .starved_o      (tag_starved_o)
    );

    bp_lce_mem_responder_port #(
        .sets_p         (sets_p),
        .assoc_p        (assoc_p),
        .entry_width_p  (data_entry_width_p),
        .starve_limit_p (starve_limit_p)
    ) u_data (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .pipe_v_i       (pipe_data_v_i),
        .mem_pkt_v_i    (data_mem_pkt_v_i),
        .mem_pkt_i      (data_mem_pkt_i),
        .mem_pkt_yumi_o (data_mem_pkt_yumi_o),
        .mem_o          (data_mem_o),
        .sram_v_o       (data_sram_v_o),
        .sram_w_o       (data_sram_w_o),
        .sram_addr_o    (data_sram_addr_o),
        .sram_data_o    (data_sram_data_o),
        .sram_mask_o    (data_sram_mask_o),
        .sram_data_i    (data_sram_data_i),
        .starved_o      (data_starved_o)
    );

    bp_lce_mem_responder_port #(
        .sets_p         (sets_p),
        .assoc_p        (assoc_p),
        .entry_width_p  (stat_entry_width_p),
        .starve_limit_p (starve_limit_p)
    ) u_stat (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .pipe_v_i       (pipe_stat_v_i),
        .mem_pkt_v_i    (stat_mem_pkt_v_i),
        .mem_pkt_i      (stat_mem_pkt_i),
        .mem_pkt_yumi_o (stat_mem_pkt_yumi_o),
        .mem_o          (stat_mem_o),
        .sram_v_o       (stat_sram_v_o),
        .sram_w_o       (stat_sram_w_o),
        .sram_addr_o    (stat_sram_addr_o),
        .sram_data_o    (stat_sram_data_o),
        .sram_mask_o    (stat_sram_mask_o),
        .sram_data_i    (stat_sram_data_i),
        .starved_o      (stat_starved_o)
    );

endmodule

// File: tb/tb_bp_lce_mem_responder.sv
// Bench for bp_lce_mem_responder: SRAM models behind each array, a per-entry
// reference memory, directed scenarios and a randomized packet stream.

module tb_bp_lce_mem_responder;

    localparam int SETS = 64, ASSOC = 8, LIMIT = 8;
    localparam int TW = 32, DW = 512, SW = 2;
    localparam int TP = 2 + 6 + 3 + 2*TW;
    localparam int DP = 2 + 6 + 3 + 2*DW;
    localparam int SP = 2 + 6 + 3 + 2*SW;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    logic                  pipe_tag_v, tag_pkt_v, tag_yumi, tag_sv, tag_sw, tag_starved;
    logic [TP-1:0]         tag_pkt;
    logic [TW-1:0]         tag_mem;
    logic [5:0]            tag_addr;
    logic [ASSOC*TW-1:0]   tag_sdata, tag_smask, tag_srd;

    logic                  pipe_data_v, data_pkt_v, data_yumi, data_sv, data_sw, data_starved;
    logic [DP-1:0]         data_pkt;
    logic [DW-1:0]         data_mem;
    logic [5:0]            data_addr;
    logic [ASSOC*DW-1:0]   data_sdata, data_smask, data_srd;

    logic                  pipe_stat_v, stat_pkt_v, stat_yumi, stat_sv, stat_sw, stat_starved;
    logic [SP-1:0]         stat_pkt;
    logic [SW-1:0]         stat_mem;
    logic [5:0]            stat_addr;
    logic [ASSOC*SW-1:0]   stat_sdata, stat_smask, stat_srd;

    bp_lce_mem_responder #(
        .sets_p(SETS), .assoc_p(ASSOC), .tag_entry_width_p(TW),
        .data_entry_width_p(DW), .stat_entry_width_p(SW), .starve_limit_p(LIMIT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pipe_tag_v_i(pipe_tag_v), .tag_mem_pkt_v_i(tag_pkt_v), .tag_mem_pkt_i(tag_pkt),
        .tag_mem_pkt_yumi_o(tag_yumi), .tag_mem_o(tag_mem), .tag_sram_v_o(tag_sv),
        .tag_sram_w_o(tag_sw), .tag_sram_addr_o(tag_addr), .tag_sram_data_o(tag_sdata),
        .tag_sram_mask_o(tag_smask), .tag_sram_data_i(tag_srd), .tag_starved_o(tag_starved),
        .pipe_data_v_i(pipe_data_v), .data_mem_pkt_v_i(data_pkt_v), .data_mem_pkt_i(data_pkt),
        .data_mem_pkt_yumi_o(data_yumi), .data_mem_o(data_mem), .data_sram_v_o(data_sv),
        .data_sram_w_o(data_sw), .data_sram_addr_o(data_addr), .data_sram_data_o(data_sdata),
        .data_sram_mask_o(data_smask), .data_sram_data_i(data_srd),
        .data_starved_o(data_starved),
        .pipe_stat_v_i(pipe_stat_v), .stat_mem_pkt_v_i(stat_pkt_v), .stat_mem_pkt_i(stat_pkt),
        .stat_mem_pkt_yumi_o(stat_yumi), .stat_mem_o(stat_mem), .stat_sram_v_o(stat_sv),
        .stat_sram_w_o(stat_sw), .stat_sram_addr_o(stat_addr), .stat_sram_data_o(stat_sdata),
        .stat_sram_mask_o(stat_smask), .stat_sram_data_i(stat_srd),
        .stat_starved_o(stat_starved)
    );

    // Single-port SRAM models with one-cycle read latency; cleared on the first edge.
    logic [ASSOC*TW-1:0] tag_row  [SETS];
    logic [ASSOC*DW-1:0] data_row [SETS];
    logic [ASSOC*SW-1:0] stat_row [SETS];
    logic sram_init = 1'b0;

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < SETS; i++) begin
                tag_row[i]  <= '0;
                data_row[i] <= '0;
                stat_row[i] <= '0;
            end
            sram_init <= 1'b1;
        end else begin
            if (tag_sv && tag_sw)
                tag_row[tag_addr] <= (tag_row[tag_addr] & ~tag_smask) | (tag_sdata & tag_smask);
            else if (tag_sv) tag_srd <= tag_row[tag_addr];
            if (data_sv && data_sw)
                data_row[data_addr] <= (data_row[data_addr] & ~data_smask)
                                       | (data_sdata & data_smask);
            else if (data_sv) data_srd <= data_row[data_addr];
            if (stat_sv && stat_sw)
                stat_row[stat_addr] <= (stat_row[stat_addr] & ~stat_smask)
                                       | (stat_sdata & stat_smask);
            else if (stat_sv) stat_srd <= stat_row[stat_addr];
        end
    end

    // Reference: one entry per (array, set, way), plus the last value each array returned.
    logic [DW-1:0] ref_mem [3][SETS*ASSOC];
    logic [DW-1:0] last_read [3];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string arr_name(input int a);
        return (a == 0) ? "tag" : (a == 1) ? "data" : "stat";
    endfunction

    function automatic int ent_w(input int a);
        return (a == 0) ? TW : (a == 1) ? DW : SW;
    endfunction

    function automatic logic [DW-1:0] ent_mask(input int a);
        logic [DW-1:0] f;
        f = '1;
        return f >> (DW - ent_w(a));
    endfunction

    function automatic logic get_yumi(input int a);
        return (a == 0) ? tag_yumi : (a == 1) ? data_yumi : stat_yumi;
    endfunction
    function automatic logic get_v(input int a);
        return (a == 0) ? tag_sv : (a == 1) ? data_sv : stat_sv;
    endfunction
    function automatic logic get_w(input int a);
        return (a == 0) ? tag_sw : (a == 1) ? data_sw : stat_sw;
    endfunction
    function automatic logic get_starved(input int a);
        return (a == 0) ? tag_starved : (a == 1) ? data_starved : stat_starved;
    endfunction
    function automatic logic [5:0] get_addr(input int a);
        return (a == 0) ? tag_addr : (a == 1) ? data_addr : stat_addr;
    endfunction
    function automatic logic [DW-1:0] get_mem(input int a);
        return (a == 0) ? DW'(tag_mem) : (a == 1) ? data_mem : DW'(stat_mem);
    endfunction
    function automatic logic [DW-1:0] get_slice(input int a, input bit msk, input int s);
        if (a == 0) return DW'(msk ? tag_smask[s*TW +: TW] : tag_sdata[s*TW +: TW]);
        if (a == 1) return msk ? data_smask[s*DW +: DW] : data_sdata[s*DW +: DW];
        return DW'(msk ? stat_smask[s*SW +: SW] : stat_sdata[s*SW +: SW]);
    endfunction

    task automatic set_pkt(input int a, input logic v, input logic [1:0] op,
                           input logic [5:0] idx, input logic [2:0] way,
                           input logic [DW-1:0] wm, input logic [DW-1:0] wd);
        case (a)
            0: begin tag_pkt_v = v;  tag_pkt  = {op, idx, way, wm[TW-1:0], wd[TW-1:0]}; end
            1: begin data_pkt_v = v; data_pkt = {op, idx, way, wm, wd}; end
            default: begin
                stat_pkt_v = v;
                stat_pkt   = {op, idx, way, wm[SW-1:0], wd[SW-1:0]};
            end
        endcase
    endtask

    task automatic set_pipe(input int a, input logic v);
        case (a)
            0: pipe_tag_v = v;
            1: pipe_data_v = v;
            default: pipe_stat_v = v;
        endcase
    endtask

    // Entered and left at posedge+1. nblk cycles of pipeline conflict precede the yumi.
    task automatic do_op(input int a, input logic [1:0] op, input logic [5:0] idx,
                         input logic [2:0] way, input logic [DW-1:0] wm_in,
                         input logic [DW-1:0] wd_in, input int nblk);
        logic [DW-1:0] fm, wm, wd, exp;
        string n;
        n  = arr_name(a);
        fm = ent_mask(a);
        wm = wm_in & fm;
        wd = wd_in & fm;
        set_pkt(a, 1'b1, op, idx, way, wm, wd);
        for (int k = 1; k <= nblk; k++) begin
            set_pipe(a, 1'b1);
            #4;
            check_eq({"blk_yumi_", n}, DW'(get_yumi(a)), '0);
            check_eq({"blk_sram_v_", n}, DW'(get_v(a)), '0);
            check_eq({"blk_starved_", n}, DW'(get_starved(a)), DW'(k >= LIMIT));
            check_eq({"blk_other_starved_", n},
                     DW'(get_starved((a + 1) % 3) | get_starved((a + 2) % 3)), '0);
            check_eq({"blk_hold_", n}, get_mem(a), last_read[a]);
            @(posedge clk); #1;
        end
        set_pipe(a, 1'b0);
        #4;
        check_eq({"yumi_", n}, DW'(get_yumi(a)), DW'(1));
        check_eq({"sram_v_", n}, DW'(get_v(a)), DW'(1));
        check_eq({"sram_w_", n}, DW'(get_w(a)), DW'(op != 2'd0));
        check_eq({"sram_addr_", n}, DW'(get_addr(a)), DW'(idx));
        check_eq({"starved_at_yumi_", n}, DW'(get_starved(a)), '0);
        check_eq({"hold_at_yumi_", n}, get_mem(a), last_read[a]);
        if (op != 2'd0) begin
            for (int s = 0; s < ASSOC; s++) begin
                check_eq({"mask_slice_", n}, get_slice(a, 1'b1, s),
                         (s == int'(way)) ? ((op == 2'd1) ? wm : fm) : '0);
                check_eq({"data_slice_", n}, get_slice(a, 1'b0, s),
                         (op == 2'd1) ? wd : '0);
            end
        end
        @(posedge clk); #1;
        set_pkt(a, 1'b0, 2'd0, 6'd0, 3'd0, '0, '0);
        if (op == 2'd1)
            ref_mem[a][idx*ASSOC + way] = (ref_mem[a][idx*ASSOC + way] & ~wm) | (wd & wm);
        else if (op == 2'd2)
            ref_mem[a][idx*ASSOC + way] = '0;
        if (op == 2'd0) begin
            exp = ref_mem[a][idx*ASSOC + way];
            #4;
            check_eq({"rd_data_", n}, get_mem(a), exp);
            check_eq({"rd_sram_idle_", n}, DW'(get_v(a)), '0);
            last_read[a] = exp;
            @(posedge clk); #1;
        end
    endtask

    task automatic b2b_reads(input int a, input logic [5:0] idx, input logic [2:0] w0,
                             input logic [2:0] w1);
        string n;
        n = arr_name(a);
        set_pkt(a, 1'b1, 2'd0, idx, w0, '0, '0);
        #4;
        check_eq({"b2b_yumi0_", n}, DW'(get_yumi(a)), DW'(1));
        @(posedge clk); #1;
        set_pkt(a, 1'b1, 2'd0, idx, w1, '0, '0);
        #4;
        check_eq({"b2b_yumi1_", n}, DW'(get_yumi(a)), DW'(1));
        check_eq({"b2b_data0_", n}, get_mem(a), ref_mem[a][idx*ASSOC + w0]);
        @(posedge clk); #1;
        set_pkt(a, 1'b0, 2'd0, 6'd0, 3'd0, '0, '0);
        #4;
        check_eq({"b2b_data1_", n}, get_mem(a), ref_mem[a][idx*ASSOC + w1]);
        last_read[a] = ref_mem[a][idx*ASSOC + w1];
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input int ncyc, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            #4;
            if (c == ncyc - 1) begin
                for (int a = 0; a < 3; a++) begin
                    check_eq({tag, "_hold_", arr_name(a)}, get_mem(a), last_read[a]);
                    check_eq({tag, "_sram_v_", arr_name(a)}, DW'(get_v(a)), '0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [DW-1:0] full;
        full = '1;
        for (int a = 0; a < 3; a++) begin
            last_read[a] = '0;
            for (int i = 0; i < SETS*ASSOC; i++) ref_mem[a][i] = '0;
        end
        pipe_tag_v = 0; pipe_data_v = 0; pipe_stat_v = 0;
        tag_srd = '0; data_srd = '0; stat_srd = '0;
        for (int a = 0; a < 3; a++) set_pkt(a, 1'b1, 2'd1, 6'd1, 3'd1, '1, '1);
        reset_i = 1'b1;

        // Reset: valid packets must not be consumed and every output stays low.
        #3;
        for (int a = 0; a < 3; a++) begin
            check_eq({"rst_yumi_", arr_name(a)}, DW'(get_yumi(a)), '0);
            check_eq({"rst_sram_v_", arr_name(a)}, DW'(get_v(a)), '0);
            check_eq({"rst_mem_", arr_name(a)}, get_mem(a), '0);
            check_eq({"rst_starved_", arr_name(a)}, DW'(get_starved(a)), '0);
        end
        @(posedge clk); @(posedge clk); #1;
        for (int a = 0; a < 3; a++) set_pkt(a, 1'b0, 2'd0, 6'd0, 3'd0, '0, '0);
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Write then read with no conflict; value must survive idle cycles.
        do_op(0, 2'd1, 6'd5, 3'd3, full, DW'(32'hDEADBEEF), 0);
        do_op(0, 2'd0, 6'd5, 3'd3, '0, '0, 0);
        idle_check(10, "idle10");

        // Pipeline conflict on a data read for three cycles.
        do_op(1, 2'd1, 6'd9, 3'd6, full, rand_wide(), 0);
        do_op(1, 2'd0, 6'd9, 3'd6, '0, '0, 3);

        // Partial-mask stat write over a zero entry.
        do_op(2, 2'd1, 6'd2, 3'd1, DW'(2'b01), DW'(2'b11), 0);
        do_op(2, 2'd0, 6'd2, 3'd1, '0, '0, 0);

        // Clear, then back-to-back reads of the cleared and a neighbouring way.
        do_op(0, 2'd1, 6'd7, 3'd0, full, DW'(32'h12345678), 0);
        do_op(0, 2'd1, 6'd7, 3'd1, full, DW'(32'hCAFEF00D), 0);
        do_op(0, 2'd2, 6'd7, 3'd0, '0, '0, 0);
        b2b_reads(0, 6'd7, 3'd0, 3'd1);

        // Starvation on tag; other arrays stay quiet.
        do_op(0, 2'd0, 6'd5, 3'd3, '0, '0, LIMIT + 2);

        // Async reset between a read handshake and its return.
        set_pkt(0, 1'b1, 2'd0, 6'd5, 3'd3, '0, '0);
        @(posedge clk); #1;
        set_pkt(1, 1'b1, 2'd0, 6'd9, 3'd6, '0, '0);
        reset_i = 1'b1;
        #1;
        check_eq("midrd_tag_mem", get_mem(0), '0);
        check_eq("midrd_data_yumi", DW'(get_yumi(1)), '0);
        check_eq("midrd_tag_sram_v", DW'(get_v(0)), '0);
        check_eq("midrd_data_sram_v", DW'(get_v(1)), '0);
        @(posedge clk); #1;
        set_pkt(0, 1'b0, 2'd0, 6'd0, 3'd0, '0, '0);
        set_pkt(1, 1'b0, 2'd0, 6'd0, 3'd0, '0, '0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        for (int a = 0; a < 3; a++) last_read[a] = '0;
        idle_check(3, "post_rst");

        // Randomized packet stream over a small index range to force reuse.
        for (int it = 0; it < 200; it++) begin
            int a, r, nblk;
            logic [1:0] op;
            logic [5:0] idx;
            logic [2:0] way, way2;
            logic [DW-1:0] wm;
            a    = $urandom_range(0, 2);
            op   = 2'($urandom_range(0, 2));
            idx  = 6'($urandom_range(0, 7));
            way  = 3'($urandom_range(0, 7));
            way2 = 3'($urandom_range(0, 7));
            r    = $urandom_range(0, 9);
            nblk = (r < 6) ? 0 : (r < 9) ? r - 5 : LIMIT + 1;
            wm   = ($urandom_range(0, 2) == 0) ? full : rand_wide();
            if ($urandom_range(0, 5) == 0) b2b_reads(a, idx, way, way2);
            else do_op(a, op, idx, way, wm, rand_wide(), nblk);
        end
        idle_check(2, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net: the stimulus is bounded, but never let a hang go unreported.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
